// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU-control decode stage.
// Holds the ALU op codes, RV32I opcodes, operand-select encodings and the decoded-entry struct.
package alu_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b01000,
        ALU_SLL  = 5'b00001,
        ALU_SLT  = 5'b00100,
        ALU_SLTU = 5'b00101,
        ALU_XOR  = 5'b00110,
        ALU_SRL  = 5'b00111,
        ALU_SRA  = 5'b10111,
        ALU_OR   = 5'b01010,
        ALU_AND  = 5'b01100
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] OPA_RS1  = 2'd0;
    localparam logic [1:0] OPA_PC   = 2'd1;
    localparam logic [1:0] OPA_ZERO = 2'd2;

    localparam logic OPB_RS2 = 1'b0;
    localparam logic OPB_IMM = 1'b1;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    // Occupancy of the output register plus skid register.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        alu_op_e         alu_op;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [1:0]      op_a_sel;
        logic            op_b_sel;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } alu_entry_t;

    // alt selects the funct7[5] variant (SUB for 000, SRA for 101); other funct3 ignore it.
    function automatic alu_op_e alu_op_from_funct3(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Unsupported encodings still travel down the pipe, tagged and with neutral controls.
    function automatic alu_entry_t illegal_entry(input logic [XLEN-1:0] pc);
        alu_entry_t e;
        e          = '0;
        e.alu_op   = ALU_ADD;
        e.pc       = pc;
        e.illegal  = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode of one instruction into an ALU-control entry.
// No state: the result depends only on the current instr and pc.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output alu_entry_t      entry
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_sh;
    logic            is_shift_imm;
    logic            op_legal;
    logic            op_imm_legal;
    logic            op_alt;
    logic            op_imm_alt;
    logic            unused_fields;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

    // Register and destination fields are not part of the ALU control word.
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    assign is_shift_imm = (f3 == F3_SLL) || (f3 == F3_SR);

    // The alternate funct7 only exists for SUB and SRA.
    assign op_legal = (f7 == F7_BASE) ||
                      ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
    assign op_alt   = (f7 == F7_ALT);

    always_comb begin
        op_imm_legal = 1'b1;
        if (f3 == F3_SLL) begin
            op_imm_legal = (f7 == F7_BASE);
        end else if (f3 == F3_SR) begin
            op_imm_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        end
    end

    // ADDI never becomes SUB, so only the right-shift variant may take the alternate op.
    assign op_imm_alt = (f3 == F3_SR) && (f7 == F7_ALT);

    always_comb begin
        entry = illegal_entry(pc);
        case (opcode)
            OPC_OP: begin
                if (op_legal) begin
                    entry.alu_op   = alu_op_from_funct3(f3, op_alt);
                    entry.funct3   = f3;
                    entry.funct7   = f7;
                    entry.op_a_sel = OPA_RS1;
                    entry.op_b_sel = OPB_RS2;
                    entry.imm      = '0;
                    entry.illegal  = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                if (op_imm_legal) begin
                    entry.alu_op   = alu_op_from_funct3(f3, op_imm_alt);
                    entry.funct3   = f3;
                    entry.funct7   = f7;
                    entry.op_a_sel = OPA_RS1;
                    entry.op_b_sel = OPB_IMM;
                    entry.imm      = is_shift_imm ? imm_sh : imm_i;
                    entry.illegal  = 1'b0;
                end
            end
            OPC_LUI: begin
                entry.alu_op   = ALU_ADD;
                entry.funct3   = F3_ADD;
                entry.funct7   = '0;
                entry.op_a_sel = OPA_ZERO;
                entry.op_b_sel = OPB_IMM;
                entry.imm      = imm_u;
                entry.illegal  = 1'b0;
            end
            OPC_AUIPC: begin
                entry.alu_op   = ALU_ADD;
                entry.funct3   = F3_ADD;
                entry.funct7   = '0;
                entry.op_a_sel = OPA_PC;
                entry.op_b_sel = OPB_IMM;
                entry.imm      = imm_u;
                entry.illegal  = 1'b0;
            end
            default: begin
                entry = illegal_entry(pc);
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_stage.sv
// Registered decode stage: output register plus one-entry skid buffer with valid/ready.
// in_ready comes from registered occupancy only, so out_ready never reaches it combinationally.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      alu_op,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [1:0]      op_a_sel,
    output logic            op_b_sel,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal
);

    occ_e       state_reg;
    occ_e       state_next;
    alu_entry_t dec_entry;
    alu_entry_t out_entry_reg;
    alu_entry_t skid_entry_reg;

    logic accept;
    logic consume;
    logic load_out_new;
    logic load_out_skid;
    logic load_skid;

    alu_ctrl_decode u_decode (
        .instr (instr),
        .pc    (pc_in),
        .entry (dec_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= OCC_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OCC_EMPTY: if (accept) state_next = OCC_ONE;
            OCC_ONE: begin
                if (accept && !consume) begin
                    state_next = OCC_TWO;
                end else if (!accept && consume) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_TWO:   if (consume) state_next = OCC_ONE;
            default:   state_next = OCC_EMPTY;
        endcase
        // Flush wins over any simultaneous accept or consume.
        if (flush) begin
            state_next = OCC_EMPTY;
        end
    end

    always_comb begin
        in_ready      = (state_reg != OCC_TWO);
        out_valid     = (state_reg != OCC_EMPTY);
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (!flush) begin
            case (state_reg)
                OCC_EMPTY: load_out_new = accept;
                OCC_ONE: begin
                    load_out_new = accept && consume;
                    load_skid    = accept && !consume;
                end
                OCC_TWO:   load_out_skid = consume;
                default: begin
                    load_out_new = 1'b0;
                end
            endcase
        end
    end

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Payload registers only move on a load, which keeps the outputs frozen under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_entry_reg  <= '0;
            skid_entry_reg <= '0;
        end else begin
            if (load_out_new) begin
                out_entry_reg <= dec_entry;
            end else if (load_out_skid) begin
                out_entry_reg <= skid_entry_reg;
            end
            if (load_skid) begin
                skid_entry_reg <= dec_entry;
            end
        end
    end

    assign alu_op   = out_entry_reg.alu_op;
    assign funct3   = out_entry_reg.funct3;
    assign funct7   = out_entry_reg.funct7;
    assign op_a_sel = out_entry_reg.op_a_sel;
    assign op_b_sel = out_entry_reg.op_b_sel;
    assign imm      = out_entry_reg.imm;
    assign pc_out   = out_entry_reg.pc;
    assign illegal  = out_entry_reg.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_alu_ctrl_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc_in;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  alu_op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [1:0]  op_a_sel;
    logic        op_b_sel;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    logic [82:0] q[$];
    logic [31:0] consumed_pcs[$];

    always #5 clk = ~clk;

    alu_ctrl_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc_in     (pc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .op_a_sel  (op_a_sel),
        .op_b_sel  (op_b_sel),
        .imm       (imm),
        .pc_out    (pc_out),
        .illegal   (illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected entry packed as {alu_op, funct3, funct7, op_a_sel, op_b_sel, imm, pc, illegal}.
    function automatic logic [82:0] model(input logic [31:0] i, input logic [31:0] pc);
        logic [4:0]  code_tbl [0:7];
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  a_op;
        logic [2:0]  o_f3;
        logic [6:0]  o_f7;
        logic [1:0]  a_sel;
        logic        b_sel;
        logic [31:0] im;
        logic        ill;
        logic        legal;
        code_tbl = '{5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10, 5'd12};
        opc = i[6:0];
        f3  = i[14:12];
        f7  = i[31:25];
        a_op = 5'd0; o_f3 = 3'd0; o_f7 = 7'd0; a_sel = 2'd0; b_sel = 1'b0; im = 32'd0; ill = 1'b1;
        if (opc == 7'h33) begin
            legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            if (legal) begin
                a_op = code_tbl[f3];
                if (f7 == 7'h20) a_op = (f3 == 3'd0) ? 5'd8 : 5'd23;
                o_f3 = f3; o_f7 = f7; ill = 1'b0;
            end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1)      legal = (f7 == 7'h00);
            else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 legal = 1'b1;
            if (legal) begin
                a_op = code_tbl[f3];
                if (f3 == 3'd5 && f7 == 7'h20) a_op = 5'd23;
                o_f3 = f3; o_f7 = f7; b_sel = 1'b1; ill = 1'b0;
                if (f3 == 3'd1 || f3 == 3'd5) im = 32'(i[24:20]);
                else                          im = 32'($signed(i[31:20]));
            end
        end else if (opc == 7'h37 || opc == 7'h17) begin
            a_sel = (opc == 7'h37) ? 2'd2 : 2'd1;
            b_sel = 1'b1;
            im    = i & 32'hFFFF_F000;
            ill   = 1'b0;
        end
        return {a_op, o_f3, o_f7, a_sel, b_sel, im, pc, ill};
    endfunction

    // Compare against the model at each falling edge, then advance it for the coming rising edge.
    always @(negedge clk) begin
        logic cons;
        logic acc;
        logic [82:0] act_e;
        if (!rst_n) begin
            q.delete();
            chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (out_valid && q.size() > 0) begin
                act_e = {alu_op, funct3, funct7, op_a_sel, op_b_sel, imm, pc_out, illegal};
                total++;
                if (act_e !== q[0]) begin
                    bad++;
                    $display("FAIL entry actual=%h expected=%h t=%0t", act_e, q[0], $time);
                end
            end
            if (flush) begin
                q.delete();
            end else begin
                cons = (q.size() > 0) && out_ready;
                acc  = in_valid && (q.size() < 2);
                if (cons) begin
                    consumed_pcs.push_back(q[0][32:1]);
                    void'(q.pop_front());
                end
                if (acc) q.push_back(model(instr, pc_in));
            end
        end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] pc);
        logic acc;
        int   n;
        instr    = ins;
        pc_in    = pc;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 100);
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout actual=stalled required=accepted pc=%h", pc);
        end
    endtask

    logic [31:0] tbl_instr [0:12];
    logic [82:0] m;

    initial begin
        tbl_instr = '{32'h002081B3, 32'h0020F1B3, 32'h0020C1B3, 32'h0020D1B3, 32'h4020D1B3,
                      32'h0010B093, 32'h00309093, 32'h40309093, 32'h80F0E093, 32'h2030D093,
                      32'h02208233, 32'h0000006F, 32'hFFF0A113};
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; pc_in = '0; out_ready = 1'b1;

        // Model pins against hand-computed values.
        m = model(32'hFF400093, 32'h0);
        chk("model_addi_imm", m[32+32:33], 32'hFFFFFFF4);
        m = model(32'h40305013, 32'h0);
        chk("model_srai_op", {27'd0, m[82:78]}, 32'h17);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fields", {alu_op, funct3, funct7, op_a_sel, op_b_sel, illegal, 13'd0}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        rst_n = 1'b1;

        send(32'hFF400093, 32'h10);
        chk("addi_valid", {31'd0, out_valid}, 32'd1);
        chk("addi_op", {27'd0, alu_op}, 32'h00);
        chk("addi_f3", {29'd0, funct3}, 32'd0);
        chk("addi_bsel", {31'd0, op_b_sel}, 32'd1);
        chk("addi_imm", imm, 32'hFFFFFFF4);
        chk("addi_illegal", {31'd0, illegal}, 32'd0);
        send(32'h402081B3, 32'h14);
        chk("sub_op", {27'd0, alu_op}, 32'h08);
        chk("sub_illegal", {31'd0, illegal}, 32'd0);
        send(32'h4020F1B3, 32'h18);
        chk("alt_f7_f3_111_illegal", {31'd0, illegal}, 32'd1);
        send(32'h40305013, 32'h1C);
        chk("srai_op", {27'd0, alu_op}, 32'h17);
        chk("srai_f3", {29'd0, funct3}, 32'd5);
        chk("srai_imm", imm, 32'h3);
        send(32'h123450B7, 32'h20);
        chk("lui_asel", {30'd0, op_a_sel}, 32'd2);
        chk("lui_imm", imm, 32'h12345000);
        send(32'h00001097, 32'h100);
        chk("auipc_asel", {30'd0, op_a_sel}, 32'd1);
        chk("auipc_pc", pc_out, 32'h100);
        send(32'h0000A083, 32'h104);
        chk("load_illegal", {31'd0, illegal}, 32'd1);
        chk("load_op", {27'd0, alu_op}, 32'h00);

        for (int k = 0; k < 13; k++) begin
            out_ready = (k % 3 != 0);
            send(tbl_instr[k], 32'h1000 + 32'(k * 4));
        end
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure: three back-to-back offers with execute stalled.
        consumed_pcs.delete();
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093; pc_in = 32'h200;
        @(posedge clk); #1;
        chk("bp_ready_after_1", {31'd0, in_ready}, 32'd1);
        instr = 32'h00200093; pc_in = 32'h204;
        @(posedge clk); #1;
        chk("bp_ready_after_2", {31'd0, in_ready}, 32'd0);
        instr = 32'h00300093; pc_in = 32'h208;
        @(posedge clk); #1;
        chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_held_pc", pc_out, 32'h200);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_second_pc", pc_out, 32'h204);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_third_pc", pc_out, 32'h208);
        @(posedge clk); #1;
        chk("bp_drained", {31'd0, out_valid}, 32'd0);
        chk("bp_count", consumed_pcs.size(), 32'd3);
        if (consumed_pcs.size() == 3) begin
            chk("bp_order0", consumed_pcs[0], 32'h200);
            chk("bp_order1", consumed_pcs[1], 32'h204);
            chk("bp_order2", consumed_pcs[2], 32'h208);
        end

        // Flush while holding two entries with a third offered.
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100113; pc_in = 32'h300;
        @(posedge clk); #1;
        instr = 32'h00200113; pc_in = 32'h304;
        @(posedge clk); #1;
        instr = 32'h00300113; pc_in = 32'h308; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush2_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        consumed_pcs.delete();
        repeat (3) @(posedge clk); #1;
        chk("flush2_nothing_out", consumed_pcs.size(), 32'd0);

        // Flush with one entry held and a new instruction offered.
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00400113; pc_in = 32'h30C;
        @(posedge clk); #1;
        instr = 32'h00500113; pc_in = 32'h310; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush1_out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while two entries are held.
        in_valid = 1'b1; instr = 32'h00100193; pc_in = 32'h400;
        @(posedge clk); #1;
        instr = 32'h00200193; pc_in = 32'h404;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_reset_full", {31'd0, in_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst_pc", pc_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h00700213; pc_in = 32'h500;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_accept", {31'd0, out_valid}, 32'd1);
        chk("post_rst_pc", pc_out, 32'h500);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
